// File: rtl/pitch_pkg.sv
// Shared types and helpers for the pitch-shift bin accumulator.
//   SIZE    : packed complex sample width {re, im}
//   SAMPLES : bins per frame (power of two)
//   IDXW    : bin index width
//   cplx_t  : packed complex sample, two's complement components
//   state_t : CLEAR (zero the RAM), ACCUM (scatter-add), DRAIN (stream out)
//   sat_add : per-component saturating complex add
package pitch_pkg;

    localparam int SIZE    = 32;
    localparam int SAMPLES = 2048;
    localparam int IDXW    = $clog2(SAMPLES);

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN} state_t;

    // One signed 16-bit add; the carry into bit 16 disagreeing with bit 15
    // means overflow, and bit 16 then tells the true sign.
    function automatic logic signed [15:0] sat16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
        logic signed [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15])
            return s[16] ? 16'sh8000 : 16'sh7FFF;
        return s[15:0];
    endfunction

    function automatic cplx_t sat_add(input cplx_t a, input cplx_t b);
        cplx_t r;
        r.re = sat16(a.re, b.re);
        r.im = sat16(a.im, b.im);
        return r;
    endfunction

endpackage

// File: rtl/bin_ram.sv
// SAMPLES x SIZE simple dual-port RAM, one write and one read port, single
// clock, registered read data.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (sampled every cycle)
//   rdata : read data, one cycle after raddr
module bin_ram #(
    parameter int SIZE    = 32,
    parameter int SAMPLES = 2048,
    parameter int AW      = $clog2(SAMPLES)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem [SAMPLES];

    // NOTE: the array and its read register carry no reset so this maps onto
    // block RAM; the owning logic zeroes the contents explicitly after reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pitch_bin_accumulator.sv
// Receive end of the pitch-shift bin remap. Scatter-accumulates
// (destination bin, complex sample) beats into a bin RAM with saturating
// adds, then on frame end streams every bin in order, clearing as it goes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake
//   in_index, in_data   : destination bin and sample to add
//   in_last             : final beat of the frame
//   out_valid/out_ready : output bin handshake
//   out_index, out_data : bin number and accumulated value
//   out_last            : high with bin SAMPLES-1
//   busy                : high while clearing or draining
module pitch_bin_accumulator #(
    parameter int SIZE    = pitch_pkg::SIZE,
    parameter int SAMPLES = pitch_pkg::SAMPLES,
    parameter int IDXW    = $clog2(SAMPLES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IDXW-1:0] in_index,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_index,
    output logic [SIZE-1:0] out_data,
    output logic            out_last,
    output logic            busy
);
    import pitch_pkg::*;

    localparam logic [IDXW-1:0] LAST_BIN = IDXW'(SAMPLES - 1);

    state_t          state, state_nxt;
    logic [IDXW-1:0] clr_cnt;
    logic            last_seen;

    // S1 holds the beat whose RAM read data is arriving; S2 records the write
    // made at the end of the previous cycle, for forwarding.
    logic            s1_valid;
    logic [IDXW-1:0] s1_idx;
    cplx_t           s1_data;
    logic            s2_valid;
    logic [IDXW-1:0] s2_idx;
    cplx_t           s2_sum;

    logic [SIZE-1:0] ram_rdata;
    cplx_t           ram_q, base, sum;
    logic            ram_we;
    logic [IDXW-1:0] ram_waddr, ram_raddr;
    logic [SIZE-1:0] ram_wdata;

    // Drain read side and the 2-entry output skid (slot 0 is the head).
    logic [IDXW-1:0] rd_cnt, rd_idx_q;
    logic            rd_done, rd_pending, rd_issue;
    logic [1:0]      sk_cnt;
    logic [IDXW-1:0] sk0_idx, sk1_idx;
    logic [SIZE-1:0] sk0_data, sk1_data;
    logic            accept, push, pop;

    assign in_ready = (state == ACCUM) && !last_seen;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ACCUM);

    assign ram_q = ram_rdata;
    // The read for S1 was issued while S2's beat was writing; if it was the
    // same bin the RAM output is stale, so take the sum S2 wrote instead.
    assign base  = (s2_valid && s2_idx == s1_idx) ? s2_sum : ram_q;
    assign sum   = sat_add(base, s1_data);

    assign out_valid = (state == DRAIN) && (sk_cnt != 2'd0);
    assign out_index = sk0_idx;
    assign out_data  = sk0_data;
    assign out_last  = out_valid && (sk0_idx == LAST_BIN);

    assign pop  = out_valid && out_ready;
    assign push = rd_pending;
    // Issue only when the skid can absorb everything already in flight.
    assign rd_issue = (state == DRAIN) && !rd_done &&
                      ((int'(sk_cnt) + int'(rd_pending) - int'(pop)) < 2);

    assign ram_raddr = (state == DRAIN) ? rd_cnt : in_index;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_cnt;
        ram_wdata = '0;
        case (state)
            CLEAR: ram_we = 1'b1;
            ACCUM: begin
                ram_we    = s1_valid;
                ram_waddr = s1_idx;
                ram_wdata = sum;
            end
            // Zero a drained bin the cycle after its read so the read and the
            // clearing write never target the same address together.
            DRAIN: begin
                ram_we    = rd_pending;
                ram_waddr = rd_idx_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == LAST_BIN)            state_nxt = ACCUM;
            ACCUM:   if (last_seen && !s1_valid)         state_nxt = DRAIN;
            DRAIN:   if (pop && out_last)                state_nxt = ACCUM;
            default:                                     state_nxt = CLEAR;
        endcase
    end

    bin_ram #(.SIZE(SIZE), .SAMPLES(SAMPLES), .AW(IDXW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            last_seen  <= 1'b0;
            s1_valid   <= 1'b0;
            s1_idx     <= '0;
            s1_data    <= '0;
            s2_valid   <= 1'b0;
            s2_idx     <= '0;
            s2_sum     <= '0;
            rd_cnt     <= '0;
            rd_idx_q   <= '0;
            rd_done    <= 1'b0;
            rd_pending <= 1'b0;
            sk_cnt     <= 2'd0;
            sk0_idx    <= '0;
            sk1_idx    <= '0;
            sk0_data   <= '0;
            sk1_data   <= '0;
        end else begin
            state <= state_nxt;

            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;

            if (state == DRAIN)
                last_seen <= 1'b0;
            else if (accept && in_last)
                last_seen <= 1'b1;

            s1_valid <= accept;
            if (accept) begin
                s1_idx  <= in_index;
                s1_data <= in_data;
            end
            s2_valid <= s1_valid && (state == ACCUM);
            s2_idx   <= s1_idx;
            s2_sum   <= sum;

            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_idx_q <= rd_cnt;
                rd_cnt   <= rd_cnt + 1'b1;
                if (rd_cnt == LAST_BIN)
                    rd_done <= 1'b1;
            end
            if (state == DRAIN && state_nxt == ACCUM)
                rd_done <= 1'b0;

            case ({push, pop})
                2'b10: begin
                    if (sk_cnt == 2'd0) begin
                        sk0_idx  <= rd_idx_q;
                        sk0_data <= ram_rdata;
                    end else begin
                        sk1_idx  <= rd_idx_q;
                        sk1_data <= ram_rdata;
                    end
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    sk0_idx  <= sk1_idx;
                    sk0_data <= sk1_data;
                    sk_cnt   <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        sk0_idx  <= rd_idx_q;
                        sk0_data <= ram_rdata;
                    end else begin
                        sk0_idx  <= sk1_idx;
                        sk0_data <= sk1_data;
                        sk1_idx  <= rd_idx_q;
                        sk1_data <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_bin_accumulator.sv
// Scoreboard bench for pitch_bin_accumulator: each frame's expected bins are
// pushed into a queue before its beats are sent; an independent monitor pops
// and compares on every output handshake and checks stall stability.
module tb_pitch_bin_accumulator;

    localparam int N = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_index = '0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_index;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    typedef struct {
        logic [10:0] idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_bins [N];
    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [42:0] prev_out = '0;

    pitch_bin_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // out_ready pattern: always 1, or ~30% duty when rand_ready is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_index, out_data}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_bin", out_index, 12'hFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check($sformatf("bin%0d_index", e.idx), out_index, e.idx);
                    check($sformatf("bin%0d_data", e.idx), out_data, e.data);
                    check($sformatf("bin%0d_last", e.idx), out_last, e.last);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_index, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) exp_bins[i] = '0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.idx  = 11'(i);
            e.data = exp_bins[i];
            e.last = (i == N - 1);
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [10:0] idx, input logic [31:0] data, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_index = idx;
        in_data  = data;
        in_last  = last;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20000) begin
            tick();
            n++;
        end
        check("drain_complete", q.size(), 0);
        q.delete();
        check("accum_in_ready", in_ready, 1);
        check("accum_busy", busy, 0);
    endtask

    task automatic reset_and_clear();
        int  cnt;
        bit  hold_ok;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 1);
        rst_n = 1'b1;
        cnt = 0;
        hold_ok = 1'b1;
        do begin
            tick();
            cnt++;
            if (!in_ready && (!busy || out_valid)) hold_ok = 1'b0;
        end while (!in_ready && cnt < 5000);
        check("clear_cycles", cnt, 2048);
        check("clear_busy", hold_ok, 1);
    endtask

    initial begin
        int n;

        // 1: reset, CLEAR length, immediate zero last beat
        reset_and_clear();
        clear_exp();
        push_frame();
        send(11'd0, 32'h0000_0000, 1'b1);
        wait_drain();

        // 2: single beat
        clear_exp();
        exp_bins[5] = 32'h0100_FF00;
        push_frame();
        send(11'd5, 32'h0100_FF00, 1'b1);
        wait_drain();

        // 3: back-to-back hits on one bin, then one more after a gap
        clear_exp();
        exp_bins[7] = 32'h0004_0004;
        push_frame();
        send(11'd7, 32'h0001_0001, 1'b0);
        send(11'd7, 32'h0001_0001, 1'b0);
        send(11'd7, 32'h0001_0001, 1'b0);
        repeat (3) tick();
        send(11'd7, 32'h0001_0001, 1'b1);
        wait_drain();

        // 4a: saturation both directions, hazard beat carrying in_last
        clear_exp();
        exp_bins[9] = 32'h7FFF_8000;
        push_frame();
        send(11'd9, 32'h7000_8100, 1'b0);
        send(11'd9, 32'h7000_8100, 1'b1);
        wait_drain();

        // 4b: cancelling components
        clear_exp();
        exp_bins[9] = 32'h0000_0000;
        push_frame();
        send(11'd9, 32'h0001_FFFF, 1'b0);
        send(11'd9, 32'hFFFF_0001, 1'b1);
        wait_drain();

        // 5: random out_ready over two frames, top-bin boundary, no residue
        rand_ready = 1'b1;
        clear_exp();
        exp_bins[0]    = 32'h0010_0020;
        exp_bins[2047] = 32'h1234_EDCC;
        push_frame();
        send(11'd0, 32'h0010_0020, 1'b0);
        send(11'd2047, 32'h1234_EDCC, 1'b1);
        wait_drain();
        clear_exp();
        exp_bins[100] = 32'h0001_0002;
        push_frame();
        send(11'd100, 32'h0001_0002, 1'b1);
        wait_drain();
        rand_ready = 1'b0;
        repeat (2) tick();

        // 6: reset in the middle of a drain
        clear_exp();
        exp_bins[1500] = 32'h0ABC_0DEF;
        push_frame();
        send(11'd1500, 32'h0ABC_0DEF, 1'b1);
        n = 0;
        while (!(out_valid && out_index == 11'd1000) && n < 10000) begin
            tick();
            n++;
        end
        check("reached_bin1000", out_index, 11'd1000);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 1);
        reset_and_clear();
        clear_exp();
        push_frame();
        send(11'd0, 32'h0000_0000, 1'b1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
